mem_mode_ctrl: RTL and testbench

MEM_MODE_CTRL -- requirements
Module: mem_mode_ctrl

---
 rtl/mem_mode_pkg.sv | 24 ++
 rtl/mem_mode_ctrl_if.sv | 76 +++++++
 rtl/mem_skid_buf.sv | 88 ++++++++
 rtl/mem_mode_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_mode_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_mode_pkg.sv
// -----------------------------------------------------------------------------
// mem_mode_pkg
// Shared encodings for the memory mode controller:
//   mem_op_e    - command opcodes carried on cmd_op
//   mem_state_e - controller FSM states
// -----------------------------------------------------------------------------
package mem_mode_pkg;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_LOAD = 2'b01,
      OP_RUN  = 2'b10,
      OP_DUMP = 2'b11
   } mem_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DUMP  = 3'd3,
      ST_DRAIN = 3'd4
   } mem_state_e;

endpackage

// File: rtl/mem_mode_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_mode_ctrl_if
// Bundles every non-clock/reset signal of mem_mode_ctrl.
//   cmd_*      command handshake (op, base address, word count)
//   abort      terminate the active operation
//   host_*     load stream into RAM
//   dump_*     dump stream out of RAM
//   proc_*     processor handoff pulses and processor RAM port
//   ram_*      single-port RAM, 1-cycle read latency
//   busy/done/aborted  status
//   load_cksum only when MEM_MODE_CTRL_CKSUM_EN is defined
// Modports: slave = controller side, master = environment side.
// -----------------------------------------------------------------------------
interface mem_mode_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_base;
   logic [ADDR_W:0]   cmd_len;
   logic              abort;

   logic              host_valid;
   logic              host_ready;
   logic [DATA_W-1:0] host_data;

   logic              dump_valid;
   logic              dump_ready;
   logic [DATA_W-1:0] dump_data;

   logic              proc_start;
   logic              proc_done;
   logic [ADDR_W-1:0] proc_addr;
   logic [DATA_W-1:0] proc_wdata;
   logic              proc_we;
   logic [DATA_W-1:0] proc_rdata;

   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;

   logic              busy;
   logic              done;
   logic              aborted;
`ifdef MEM_MODE_CTRL_CKSUM_EN
   logic [DATA_W-1:0] load_cksum;
`endif

   modport slave (
      input  cmd_valid, cmd_op, cmd_base, cmd_len, abort,
      input  host_valid, host_data, dump_ready,
      input  proc_done, proc_addr, proc_wdata, proc_we, ram_rdata,
      output cmd_ready, host_ready, dump_valid, dump_data,
      output proc_start, proc_rdata, ram_addr, ram_wdata, ram_we,
`ifdef MEM_MODE_CTRL_CKSUM_EN
      output load_cksum,
`endif
      output busy, done, aborted
   );

   modport master (
      output cmd_valid, cmd_op, cmd_base, cmd_len, abort,
      output host_valid, host_data, dump_ready,
      output proc_done, proc_addr, proc_wdata, proc_we, ram_rdata,
      input  cmd_ready, host_ready, dump_valid, dump_data,
      input  proc_start, proc_rdata, ram_addr, ram_wdata, ram_we,
`ifdef MEM_MODE_CTRL_CKSUM_EN
      input  load_cksum,
`endif
      input  busy, done, aborted
   );

endinterface

// File: rtl/mem_skid_buf.sv
// -----------------------------------------------------------------------------
// mem_skid_buf
// Two-entry buffer between the RAM read port and the dump stream.
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            empty the buffer (wins over a push in the same cycle)
//   in_valid/in_data write one word (caller guarantees no overflow)
//   out_valid/out_ready/out_data  stream side; out_data is the head register
//                    so it cannot change while out_valid=1 and out_ready=0
//   count            current occupancy 0..2
// -----------------------------------------------------------------------------
module mem_skid_buf #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] tail_q, tail_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              pop;

   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = head_q;
   assign count     = cnt_q;
   assign pop       = out_valid && out_ready;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (flush) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = 2'd0;
      end else begin
         case (cnt_q)
            2'd0: begin
               if (in_valid) begin
                  head_d = in_data;
                  cnt_d  = 2'd1;
               end
            end
            2'd1: begin
               if (in_valid && pop) begin
                  head_d = in_data;
               end else if (in_valid) begin
                  tail_d = in_data;
                  cnt_d  = 2'd2;
               end else if (pop) begin
                  cnt_d  = 2'd0;
               end
            end
            default: begin
               // Full: the tail moves up to the head on a pop.
               if (pop) begin
                  head_d = tail_q;
                  if (in_valid) begin
                     tail_d = in_data;
                  end else begin
                     cnt_d = 2'd1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_mode_ctrl.sv
// -----------------------------------------------------------------------------
// mem_mode_ctrl
// Arbitrates a single-port RAM between three modes:
//   LOAD - host stream writes cmd_len words from cmd_base (address wraps)
//   RUN  - RAM port handed to the processor until proc_done
//   DUMP - cmd_len words read from cmd_base onto the dump stream
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mem_mode_ctrl_if.slave (command, host, dump, processor, RAM, status)
// Optional feature: define MEM_MODE_CTRL_CKSUM_EN to add bus.load_cksum, the
// mod-2^DATA_W sum of words written by the most recent LOAD.
// -----------------------------------------------------------------------------
module mem_mode_ctrl
   import mem_mode_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input logic            clk,
   input logic            rst_n,
   mem_mode_ctrl_if.slave bus
);

   localparam int LEN_W = ADDR_W + 1;

   mem_state_e        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [LEN_W-1:0]  idx_inc;
   logic              rd_pend_q, rd_pend_d;
   logic              done_q, done_d;
   logic              aborted_q, aborted_d;
   logic              start_q, start_d;
`ifdef MEM_MODE_CTRL_CKSUM_EN
   logic [DATA_W-1:0] cksum_q, cksum_d;
`endif

   logic [ADDR_W-1:0] ram_addr_c;
   logic [DATA_W-1:0] ram_wdata_c;
   logic              ram_we_c;
   logic              host_ready_c;
   logic              sb_flush;
   logic              sb_valid;
   logic [DATA_W-1:0] sb_data;
   logic [1:0]        sb_count;
   logic              pop;
   logic [2:0]        occ;
   logic              active_abort;

   assign idx_inc      = idx_q + 1'b1;
   assign pop          = sb_valid && bus.dump_ready;
   assign active_abort = bus.abort && (state_q != ST_IDLE);
   // Buffer occupancy one cycle from now, counting the read already in flight.
   // A new read is only safe if that leaves room for its data next cycle
   // even when the consumer stalls.
   assign occ = {1'b0, sb_count} + {2'b00, rd_pend_q} - {2'b00, pop};

   mem_skid_buf #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (sb_flush),
      .in_valid  (rd_pend_q),
      .in_data   (bus.ram_rdata),
      .out_valid (sb_valid),
      .out_ready (bus.dump_ready),
      .out_data  (sb_data),
      .count     (sb_count)
   );

   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      len_d        = len_q;
      idx_d        = idx_q;
      rd_pend_d    = 1'b0;
      done_d       = 1'b0;
      aborted_d    = 1'b0;
      start_d      = 1'b0;
      sb_flush     = 1'b0;
      ram_addr_c   = '0;
      ram_wdata_c  = '0;
      ram_we_c     = 1'b0;
      host_ready_c = 1'b0;
`ifdef MEM_MODE_CTRL_CKSUM_EN
      cksum_d      = cksum_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               base_d = bus.cmd_base;
               len_d  = bus.cmd_len;
               idx_d  = '0;
               case (mem_op_e'(bus.cmd_op))
                  OP_LOAD: begin
`ifdef MEM_MODE_CTRL_CKSUM_EN
                     cksum_d = '0;
`endif
                     // Zero-length transfers complete without leaving IDLE.
                     if (bus.cmd_len == '0) done_d  = 1'b1;
                     else                   state_d = ST_LOAD;
                  end
                  OP_DUMP: begin
                     if (bus.cmd_len == '0) done_d  = 1'b1;
                     else                   state_d = ST_DUMP;
                  end
                  OP_RUN: begin
                     state_d = ST_RUN;
                     start_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end

         ST_LOAD: begin
            host_ready_c = !bus.abort;
            ram_addr_c   = base_q + idx_q[ADDR_W-1:0];
            ram_wdata_c  = bus.host_data;
            if (bus.host_valid && !bus.abort) begin
               ram_we_c = 1'b1;
               idx_d    = idx_inc;
`ifdef MEM_MODE_CTRL_CKSUM_EN
               cksum_d  = cksum_q + bus.host_data;
`endif
               if (idx_inc == len_q) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         ST_RUN: begin
            ram_addr_c  = bus.proc_addr;
            ram_wdata_c = bus.proc_wdata;
            ram_we_c    = bus.proc_we;
            if (bus.proc_done) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end

         ST_DUMP: begin
            if (occ <= 3'd1) begin
               ram_addr_c = base_q + idx_q[ADDR_W-1:0];
               idx_d      = idx_inc;
               rd_pend_d  = 1'b1;
               if (idx_inc == len_q) state_d = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            // All reads issued; finish on the handshake that empties the buffer.
            if (!rd_pend_q && (sb_count == 2'd1) && pop) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Abort overrides every completion path in the same cycle.
      if (active_abort) begin
         state_d   = ST_IDLE;
         done_d    = 1'b0;
         aborted_d = 1'b1;
         sb_flush  = 1'b1;
         rd_pend_d = 1'b0;
         ram_we_c  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         base_q    <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         rd_pend_q <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         start_q   <= 1'b0;
`ifdef MEM_MODE_CTRL_CKSUM_EN
         cksum_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         rd_pend_q <= rd_pend_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         start_q   <= start_d;
`ifdef MEM_MODE_CTRL_CKSUM_EN
         cksum_q   <= cksum_d;
`endif
      end
   end

   assign bus.cmd_ready  = (state_q == ST_IDLE);
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.host_ready = host_ready_c;
   assign bus.dump_valid = sb_valid;
   assign bus.dump_data  = sb_data;
   assign bus.proc_start = start_q;
   assign bus.proc_rdata = (state_q == ST_RUN) ? bus.ram_rdata : '0;
   assign bus.ram_addr   = ram_addr_c;
   assign bus.ram_wdata  = ram_wdata_c;
   assign bus.ram_we     = ram_we_c;
   assign bus.done       = done_q;
   assign bus.aborted    = aborted_q;
`ifdef MEM_MODE_CTRL_CKSUM_EN
   assign bus.load_cksum = cksum_q;
`endif

endmodule

// File: tb/tb_mem_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_mode_ctrl
// Directed bench for mem_mode_ctrl with a behavioural 1-cycle-latency RAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 4 time units after the edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_mode_ctrl;

   localparam logic [1:0] C_NOP  = 2'b00;
   localparam logic [1:0] C_LOAD = 2'b01;
   localparam logic [1:0] C_RUN  = 2'b10;
   localparam logic [1:0] C_DUMP = 2'b11;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_mode_ctrl_if #(.DATA_W(16), .ADDR_W(8)) bus ();

   mem_mode_ctrl #(.DATA_W(16), .ADDR_W(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // RAM model: contents reloaded with mem[a] = a while reset is low.
   logic [15:0] mem [256];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int a = 0; a < 256; a++) mem[a] <= 16'(a);
         bus.ram_rdata <= '0;
      end else begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
         bus.ram_rdata <= mem[bus.ram_addr];
      end
   end

   int n_cmp = 0;
   int n_bad = 0;
   int nwords, first_c, last_c, ndone, done_c, nstart, nbusy;
   logic        held_valid;
   logic [15:0] held_data;
   logic [7:0]  load_addr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Called at edge+1 in IDLE; returns at edge+1 of the first cycle after accept.
   task automatic send_cmd(input logic [1:0] op, input logic [7:0] base, input logic [8:0] len);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_base  = base;
      bus.cmd_len   = len;
      #3;
      check_eq("cmd_ready_at_accept", bus.cmd_ready, 1);
      tick;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = C_NOP;
      $display("cmd op=%0d base=0x%0h len=%0d", op, base, len);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_base = 0; bus.cmd_len = 0;
      bus.abort = 0; bus.host_valid = 0; bus.host_data = 0; bus.dump_ready = 0;
      bus.proc_done = 0; bus.proc_addr = 0; bus.proc_wdata = 0; bus.proc_we = 0;

      // ---- reset values ----
      tick; tick; tick;
      #3;
      check_eq("rst_cmd_ready",  bus.cmd_ready, 1);
      check_eq("rst_host_ready", bus.host_ready, 0);
      check_eq("rst_dump_valid", bus.dump_valid, 0);
      check_eq("rst_dump_data",  bus.dump_data, 0);
      check_eq("rst_proc_start", bus.proc_start, 0);
      check_eq("rst_ram_we",     bus.ram_we, 0);
      check_eq("rst_ram_addr",   bus.ram_addr, 0);
      check_eq("rst_ram_wdata",  bus.ram_wdata, 0);
      check_eq("rst_busy",       bus.busy, 0);
      check_eq("rst_done",       bus.done, 0);
      check_eq("rst_aborted",    bus.aborted, 0);
`ifdef MEM_MODE_CTRL_CKSUM_EN
      check_eq("rst_cksum",      bus.load_cksum, 0);
`endif
      tick;
      rst_n = 1'b1;
      tick;

      // ---- NOP: no state change, no done ----
      send_cmd(C_NOP, 8'h00, 9'd5);
      #3;
      check_eq("nop_busy", bus.busy, 0);
      check_eq("nop_done", bus.done, 0);
      tick;

      // ---- LOAD with address wrap ----
      send_cmd(C_LOAD, 8'hFE, 9'd4);
      for (int i = 0; i < 4; i++) begin
         bus.host_valid = 1'b1;
         bus.host_data  = 16'(i + 1);
         #3;
         check_eq("load_host_ready", bus.host_ready, 1);
         check_eq("load_we",         bus.ram_we, 1);
         check_eq("load_addr",       bus.ram_addr, load_addr[i]);
         check_eq("load_wdata",      bus.ram_wdata, i + 1);
         check_eq("load_no_early_done", bus.done, 0);
         $display("load write addr=0x%0h data=0x%0h", bus.ram_addr, bus.ram_wdata);
         tick;
      end
      bus.host_valid = 1'b0;
      #3;
      check_eq("load_done",  bus.done, 1);
      check_eq("load_busy",  bus.busy, 0);
      check_eq("ram_0xfe",   mem[8'hFE], 1);
      check_eq("ram_0xff",   mem[8'hFF], 2);
      check_eq("ram_0x00",   mem[8'h00], 3);
      check_eq("ram_0x01",   mem[8'h01], 4);
      tick;
      #3;
      check_eq("load_done_pulse", bus.done, 0);
      tick;

      // ---- DUMP at full rate ----
      bus.dump_ready = 1'b1;
      send_cmd(C_DUMP, 8'h10, 9'd8);
      nwords = 0; first_c = -1; last_c = -1; ndone = 0; done_c = -1;
      for (int c = 0; c < 20; c++) begin
         #3;
         if (bus.dump_valid && bus.dump_ready) begin
            check_eq("dump_data", bus.dump_data, 32'h10 + nwords);
            $display("dump word %0d data=0x%0h cycle=%0d", nwords, bus.dump_data, c);
            if (first_c < 0) first_c = c;
            last_c = c;
            nwords++;
         end
         if (bus.done) begin
            ndone++;
            done_c = c;
         end
         tick;
      end
      check_eq("dump_first_cycle", first_c, 2);
      check_eq("dump_last_cycle",  last_c, 9);
      check_eq("dump_word_count",  nwords, 8);
      check_eq("dump_done_count",  ndone, 1);
      check_eq("dump_done_cycle",  done_c, 10);

      // ---- DUMP with stalling consumer ----
      send_cmd(C_DUMP, 8'h10, 9'd3);
      nwords = 0; ndone = 0; held_valid = 1'b0; held_data = '0;
      for (int c = 0; c < 40; c++) begin
         bus.dump_ready = (c % 3 == 0);
         #3;
         if (held_valid) begin
            check_eq("stall_valid_held", bus.dump_valid, 1);
            check_eq("stall_data_held",  bus.dump_data, held_data);
         end
         if (bus.dump_valid && bus.dump_ready) begin
            check_eq("stall_dump_data", bus.dump_data, 32'h10 + nwords);
            $display("stall dump word %0d data=0x%0h cycle=%0d", nwords, bus.dump_data, c);
            nwords++;
         end
         held_valid = bus.dump_valid && !bus.dump_ready;
         held_data  = bus.dump_data;
         if (bus.done) ndone++;
         tick;
      end
      bus.dump_ready = 1'b1;
      check_eq("stall_word_count", nwords, 3);
      check_eq("stall_done_count", ndone, 1);

      // ---- RUN handoff ----
      send_cmd(C_RUN, 8'h00, 9'd0);
      nstart = 0; nbusy = 0; ndone = 0;
      for (int c = 0; c < 30; c++) begin
         bus.proc_we    = (c == 5);
         bus.proc_addr  = (c >= 5) ? 8'h40 : 8'h00;
         bus.proc_wdata = 16'hBEEF;
         bus.proc_done  = (c == 20);
         #3;
         if (c == 5) begin
            check_eq("run_ram_we",   bus.ram_we, 1);
            check_eq("run_ram_addr", bus.ram_addr, 8'h40);
         end
         if (c == 8) check_eq("run_proc_rdata", bus.proc_rdata, 16'hBEEF);
         nstart += int'(bus.proc_start);
         nbusy  += int'(bus.busy);
         ndone  += int'(bus.done);
         tick;
      end
      bus.proc_we = 1'b0;
      bus.proc_done = 1'b0;
      $display("run start_pulses=%0d busy_cycles=%0d", nstart, nbusy);
      check_eq("run_start_pulses", nstart, 1);
      check_eq("run_busy_cycles",  nbusy, 21);
      check_eq("run_done_count",   ndone, 1);
      check_eq("run_ram_0x40",     mem[8'h40], 16'hBEEF);

      // proc port inert outside RUN
      bus.proc_we = 1'b1; bus.proc_addr = 8'h40; bus.proc_wdata = 16'h1234;
      #3;
      check_eq("idle_ram_we",     bus.ram_we, 0);
      check_eq("idle_proc_rdata", bus.proc_rdata, 0);
      tick;
      bus.proc_we = 1'b0;
      #3;
      check_eq("idle_ram_0x40", mem[8'h40], 16'hBEEF);
      tick;

      // ---- abort during DUMP at word 2 ----
      bus.dump_ready = 1'b1;
      send_cmd(C_DUMP, 8'h10, 9'd8);
      for (int c = 0; c < 4; c++) tick;
      bus.abort = 1'b1;
      #3;
      check_eq("abort_word2_data", bus.dump_data, 16'h12);
      check_eq("abort_not_yet",    bus.aborted, 0);
      tick;
      bus.abort = 1'b0;
      #3;
      check_eq("abort_pulse",      bus.aborted, 1);
      check_eq("abort_dump_valid", bus.dump_valid, 0);
      check_eq("abort_cmd_ready",  bus.cmd_ready, 1);
      check_eq("abort_busy",       bus.busy, 0);
      check_eq("abort_no_done",    bus.done, 0);
      $display("abort observed aborted=%0d", bus.aborted);
      tick;
      #3;
      check_eq("abort_pulse_end",  bus.aborted, 0);
      check_eq("abort_stays_empty", bus.dump_valid, 0);
      tick;
      send_cmd(C_LOAD, 8'h00, 9'd0);
      #3;
      check_eq("load0_done", bus.done, 1);
      check_eq("load0_busy", bus.busy, 0);
      tick;

      // abort in IDLE is ignored
      bus.abort = 1'b1;
      #3;
      tick;
      bus.abort = 1'b0;
      #3;
      check_eq("idle_abort_ignored", bus.aborted, 0);
      tick;

`ifdef MEM_MODE_CTRL_CKSUM_EN
      // ---- checksum wraps mod 2^16 ----
      send_cmd(C_LOAD, 8'h80, 9'd2);
      bus.host_valid = 1'b1;
      bus.host_data  = 16'hFFFF;
      tick;
      bus.host_data  = 16'h0002;
      tick;
      bus.host_valid = 1'b0;
      #3;
      check_eq("cksum_value", bus.load_cksum, 16'h0001);
      $display("cksum=0x%0h", bus.load_cksum);
      tick;
`endif

      // ---- asynchronous reset mid-LOAD ----
      send_cmd(C_LOAD, 8'h20, 9'd4);
      bus.host_valid = 1'b1;
      bus.host_data  = 16'h0055;
      tick;
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_busy",       bus.busy, 0);
      check_eq("arst_cmd_ready",  bus.cmd_ready, 1);
      check_eq("arst_host_ready", bus.host_ready, 0);
      check_eq("arst_ram_we",     bus.ram_we, 0);
      check_eq("arst_ram_addr",   bus.ram_addr, 0);
      check_eq("arst_ram_wdata",  bus.ram_wdata, 0);
      check_eq("arst_dump_valid", bus.dump_valid, 0);
      check_eq("arst_dump_data",  bus.dump_data, 0);
      check_eq("arst_done",       bus.done, 0);
      check_eq("arst_aborted",    bus.aborted, 0);
`ifdef MEM_MODE_CTRL_CKSUM_EN
      check_eq("arst_cksum",      bus.load_cksum, 0);
`endif
      $display("async reset applied mid-load");
      bus.host_valid = 1'b0;
      tick; tick;
      rst_n = 1'b1;
      tick;
      #3;
      check_eq("post_rst_done",    bus.done, 0);
      check_eq("post_rst_aborted", bus.aborted, 0);
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
